// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide,
// plus MTHI/MTLO, with a busy flag for pipeline stalls.
module muldiv_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);
   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_W-1:0]     r_opnd;
   logic [DATA_W-1:0]     r_raw1;
   logic [2*DATA_W-1:0]   r_acc;
   logic                  r_neg_res;
   logic                  r_neg_rem;
   logic                  r_dz;

   logic                  w_signed;
   logic                  w_s1;
   logic                  w_s2;
   logic [DATA_W-1:0]     w_abs1;
   logic [DATA_W-1:0]     w_abs2;
   logic                  w_accept;
   logic                  w_last;
   logic [DATA_W:0]       w_madd;
   logic [2*DATA_W-1:0]   w_mstep;
   logic [DATA_W:0]       w_dshift;
   logic [DATA_W+1:0]     w_ddiff;
   logic [2*DATA_W-1:0]   w_dstep;
   logic [2*DATA_W-1:0]   w_prod;
   logic [DATA_W-1:0]     w_quo;
   logic [DATA_W-1:0]     w_rem;

   // Signed variants are the even opcodes (MULT, DIV); iterate on magnitudes.
   assign w_signed = ~op[0];
   assign w_s1     = w_signed & in1[DATA_W-1];
   assign w_s2     = w_signed & in2[DATA_W-1];
   assign w_abs1   = w_s1 ? -in1 : in1;
   assign w_abs2   = w_s2 ? -in2 : in2;
   assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !flush;
   assign w_last   = (r_cnt == CNT_W'(DATA_W));

   // Multiply: acc = {partial, multiplier}; add on LSB, then shift right with carry.
   assign w_madd  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd} : {(DATA_W+1){1'b0}});
   assign w_mstep = {w_madd, r_acc[DATA_W-1:1]};

   // Divide: acc = {remainder, dividend/quotient}; trial-subtract, keep on no borrow.
   assign w_dshift = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
   assign w_ddiff  = {1'b0, w_dshift} - {2'b00, r_opnd};
   assign w_dstep  = w_ddiff[DATA_W+1] ? {w_dshift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                                       : {w_ddiff[DATA_W-1:0],  r_acc[DATA_W-2:0], 1'b1};

   assign w_prod = r_neg_res ? -r_acc : r_acc;
   assign w_quo  = r_neg_res ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
   assign w_rem  = r_neg_rem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

   // Sequencer, operand latches, iteration datapath and HI/LO registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_opnd      <= '0;
         r_raw1      <= '0;
         r_acc       <= '0;
         r_neg_res   <= 1'b0;
         r_neg_rem   <= 1'b0;
         r_dz        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               r_state <= S_IDLE;
               if (w_accept) begin
                  case (op)
                     3'd0, 3'd1: begin
                        r_state   <= S_MUL;
                        busy      <= 1'b1;
                        r_cnt     <= '0;
                        r_opnd    <= w_abs1;
                        r_acc     <= {{DATA_W{1'b0}}, w_abs2};
                        r_neg_res <= w_s1 ^ w_s2;
                     end
                     3'd2, 3'd3: begin
                        r_state   <= S_DIV;
                        busy      <= 1'b1;
                        r_cnt     <= '0;
                        r_opnd    <= w_abs2;
                        r_acc     <= {{DATA_W{1'b0}}, w_abs1};
                        r_neg_res <= w_s1 ^ w_s2;
                        r_neg_rem <= w_s1;
                        r_raw1    <= in1;
                        r_dz      <= (in2 == {DATA_W{1'b0}});
                     end
                     3'd4:    hi <= in1;
                     3'd5:    lo <= in1;
                     default: r_state <= S_IDLE;
                  endcase
               end
            end
            S_MUL: begin
               if (flush) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end else if (w_last) begin
                  {hi, lo} <= w_prod;
                  r_state  <= S_DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  r_acc <= w_mstep;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DIV: begin
               if (flush) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end else if (w_last) begin
                  // A zero divisor still runs all steps, then reports raw dividend.
                  hi          <= r_dz ? r_raw1 : w_rem;
                  lo          <= r_dz ? {DATA_W{1'b1}} : w_quo;
                  div_by_zero <= r_dz;
                  r_state     <= S_DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
               end else begin
                  r_acc <= w_dstep;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end
endmodule
